simd_sequencer: RTL and testbench
=================================

Name: simd_sequencer

Overview:
- Control FSM that sequences one 4-lane SIMD operation: serial operand load, ALU settle, serial result unload.
- Sits between the host interface (SPI/byte-stream side) and the SIMD datapath.
- Drives the datapath's load, send, mode and dtype inputs.
- Provides valid/ready handshakes so the upstream source and downstream sink can stall the shift sequences.

Parameters:
- BW, 32, operand/result width in bits; equals the SIPO/PISO shift length.
- SETTLE_CYC, 1, cycles between the last load beat and the first send beat (ALU combinational settle); legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- mode_in  input  4  ALU mode to latch on start.
- dtype_in  input  1  ALU data type to latch on start.
- abort  input  1  synchronous abort; returns the FSM to IDLE.
- in_valid  input  1  upstream operand byte (8 lane bits) valid this cycle.
- in_ready  output  1  sequencer accepts an operand byte this cycle.
- out_ready  input  1  downstream accepts a result nibble this cycle.
- out_valid  output  1  datapath serial result bits are valid this cycle.
- load  output  1  datapath SIPO shift enable.
- send  output  1  datapath PISO enable; the first asserted cycle captures, later cycles shift.
- mode  output  4  latched ALU mode, held for the whole operation.
- dtype  output  1  latched ALU data type.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- beat_cnt  output  $clog2(BW+1)+1  current beat count, for debug/verification.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, mode=0, dtype=0.
  - load, send, in_ready, out_valid, busy and done are all 0.
  - Reset takes effect immediately, even mid-operation; no partial pulse is emitted afterwards.
- States: IDLE, LOAD, SETTLE, SEND, DONE.
- IDLE:
  - On start=1: latch mode<=mode_in and dtype<=dtype_in, set cnt<=0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - in_ready=1.
  - load = in_valid (combinational); each cycle with in_valid=1 is one beat and cnt increments.
  - in_valid=0 stalls: load=0 and cnt holds.
  - On the beat where cnt==BW-1: set cnt<=0 and go to SETTLE. Exactly BW load pulses per operation.
- SETTLE:
  - load=send=0.
  - cnt counts to SETTLE_CYC-1, then cnt<=0 and go to SEND.
- SEND:
  - send = out_ready; cnt increments on each send beat.
  - Beat 0 (cnt==0) is the PISO capture beat; out_valid=0 on it.
  - Beats 1..BW are shift beats; out_valid = (cnt>=1) && out_ready.
  - out_ready=0 stalls: send=0 and cnt holds.
  - After beat cnt==BW go to DONE. Total BW+1 send pulses.
- DONE:
  - done=1 for exactly one cycle, busy=1; then go to IDLE.
- start outside IDLE is ignored; it is neither queued nor re-latched.
- mode and dtype stay constant from the latch cycle until the next accepted start, including through IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and cnt<=0; no done pulse.
  - load and send are forced to 0 in the abort cycle, combinationally.
  - abort has priority over all other transitions; abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins, because abort has no effect in IDLE.
- busy = (state != IDLE).
- cnt width is $clog2(BW+1)+1 bits so the counter never wraps before the terminal compare.

Decomposition:
- Shared package simd_pkg holds:
  - state enum (IDLE, LOAD, SETTLE, SEND, DONE);
  - mode encoding constants used by the ALU;
  - default BW constant.
- One natural sub-module, simd_beat_counter: enable/clear counter with a terminal-count flag, instantiated once and reused across LOAD, SETTLE and SEND.
- Everything else stays in the single FSM module.

Test Plan:
- Basic operation, BW=32, SETTLE_CYC=1: reset, start with mode_in=4'h2, dtype_in=1, in_valid and out_ready held high. Required: exactly 32 load pulses, then 1 idle cycle, then 33 send pulses with out_valid high on the last 32, then done high for 1 cycle; mode=4'h2 throughout.
- Load stalls: in_valid toggling 1,0,0,1,... Required: load equals in_valid, cnt holds on stall cycles, LOAD exits only after the 32nd accepted beat.
- Send stalls: out_ready low for 5 cycles at send beat 10. Required: send=0 and out_valid=0 for those 5 cycles, cnt stays at 10, completion is delayed by exactly 5 cycles.
- Abort mid-load: abort at load beat 12. Required: load=0 in the same cycle, IDLE on the next cycle, done is never asserted; a following start runs a full 32-beat load.
- Async reset mid-send: rst=0 at send beat 20 between clock edges. Required: all outputs 0 immediately; after release, state is IDLE and busy=0.
- Start while busy: pulse start with mode_in=4'hF during SETTLE. Required: ignored, mode remains the originally latched value, one done pulse only.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD operation sequencer.
//   - state_e     : sequencer FSM states
//   - MODE_*      : ALU mode encodings driven onto the datapath mode bus
//   - DEFAULT_BW  : default operand/result width (SIPO/PISO shift length)
//   - cnt_width() : beat counter width, one spare bit above what BW needs
package simd_pkg;

  localparam int DEFAULT_BW = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SEND   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [3:0] MODE_ADD = 4'h0;
  localparam logic [3:0] MODE_SUB = 4'h1;
  localparam logic [3:0] MODE_MUL = 4'h2;
  localparam logic [3:0] MODE_AND = 4'h3;
  localparam logic [3:0] MODE_OR  = 4'h4;
  localparam logic [3:0] MODE_XOR = 4'h5;
  localparam logic [3:0] MODE_MIN = 4'h6;
  localparam logic [3:0] MODE_MAX = 4'h7;

  // The extra bit keeps the counter from wrapping before the SEND terminal
  // compare at cnt == BW.
  function automatic int cnt_width(input int bw);
    return $clog2(bw + 1) + 1;
  endfunction

endpackage

// File: rtl/simd_beat_counter.sv
// Enable/clear beat counter with a terminal-count flag.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear to zero (priority over en_i)
//   en_i    : count one beat
//   term_i  : terminal value for the current phase
//   cnt_o   : current count
//   tc_o    : high while cnt_o equals term_i
module simd_beat_counter #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/simd_sequencer.sv
// Control FSM sequencing one 4-lane SIMD operation: serial operand load,
// ALU settle, serial result unload, one-cycle done pulse.
// Ports:
//   clk, rst (async active-low)
//   start, mode_in, dtype_in : operation request, sampled in IDLE only
//   abort                    : synchronous return to IDLE from any busy state
//   in_valid / in_ready      : upstream operand byte handshake
//   out_ready / out_valid    : downstream result handshake
//   load, send, mode, dtype  : datapath controls
//   busy, done, beat_cnt     : status and debug
module simd_sequencer
  import simd_pkg::*;
#(
  parameter int BW         = DEFAULT_BW,
  parameter int SETTLE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             mode_in,
  input  logic                   dtype_in,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   load,
  output logic                   send,
  output logic [3:0]             mode,
  output logic                   dtype,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(BW+1):0]  beat_cnt
);

  localparam int CW = cnt_width(BW);

  state_e         state_q, state_d;
  logic [3:0]     mode_q, mode_d;
  logic           dtype_q, dtype_d;
  logic           abort_act;
  logic           cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0]  cnt, cnt_term;

  // abort only matters once an operation is running
  assign abort_act = abort && (state_q != IDLE);

  // Terminal value depends on the phase the shared counter is timing.
  always_comb begin
    cnt_term = '0;
    unique case (state_q)
      LOAD:    cnt_term = CW'(BW - 1);
      SETTLE:  cnt_term = CW'(SETTLE_CYC - 1);
      SEND:    cnt_term = CW'(BW);
      default: cnt_term = '0;
    endcase
  end

  simd_beat_counter #(.W(CW)) u_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_ADD;
      dtype_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dtype_q <= dtype_d;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dtype_d = dtype_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (abort_act) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_clr = 1'b1;
          if (start) begin
            mode_d  = mode_in;
            dtype_d = dtype_in;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt_tc) begin
              cnt_clr = 1'b1;
              state_d = SETTLE;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = SEND;
          end else begin
            cnt_en = 1'b1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (cnt_tc) begin
              cnt_clr = 1'b1;
              state_d = DONE;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        DONE: begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end
        default: begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs; load/send are suppressed in an abort cycle so the datapath
  // never sees a partial beat.
  always_comb begin
    in_ready  = (state_q == LOAD);
    load      = (state_q == LOAD) && in_valid && !abort;
    send      = (state_q == SEND) && out_ready && !abort;
    // beat 0 of SEND is the PISO capture, no result bit yet
    out_valid = (state_q == SEND) && out_ready && (cnt != '0);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  assign mode     = mode_q;
  assign dtype    = dtype_q;
  assign beat_cnt = cnt;

endmodule

// File: tb/tb_simd_sequencer.sv
module tb_simd_sequencer;

  localparam int BW = 32;
  localparam int SC = 1;
  localparam int CW = $clog2(BW + 1) + 1;
  localparam int BL = 11 + CW;  // {busy,in_ready,load,send,out_valid,done,mode,dtype,cnt}

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    mode_in = 4'h0;
  logic          dtype_in = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, load, send, dtype, busy, done;
  logic [3:0]    mode;
  logic [CW-1:0] beat_cnt;

  simd_sequencer #(.BW(BW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .dtype_in(dtype_in),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .out_valid(out_valid), .load(load), .send(send), .mode(mode), .dtype(dtype),
    .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: progress of the current operation as plain beat tallies.
  bit         m_active;
  int         m_loads, m_settles, m_sends;
  logic [3:0] m_mode;
  bit         m_dtype;
  int         n_load, n_send, n_ov, n_done;

  function automatic logic [BL-1:0] model_expect(bit ab, bit iv, bit ordy);
    bit ld_ph, st_ph, sd_ph, dn_ph;
    int c;
    ld_ph = m_active && (m_loads < BW);
    st_ph = m_active && (m_loads == BW) && (m_settles < SC);
    sd_ph = m_active && (m_loads == BW) && (m_settles == SC) && (m_sends <= BW);
    dn_ph = m_active && (m_sends == BW + 1);
    c = ld_ph ? m_loads : st_ph ? m_settles : sd_ph ? m_sends : 0;
    return {m_active, ld_ph, ld_ph && iv && !ab, sd_ph && ordy && !ab,
            sd_ph && ordy && (m_sends >= 1), dn_ph, m_mode, m_dtype, CW'(c)};
  endfunction

  task automatic model_update(bit s, logic [3:0] mi, bit di, bit ab, bit iv, bit ordy);
    if (!m_active) begin
      if (s) begin
        m_active = 1; m_loads = 0; m_settles = 0; m_sends = 0;
        m_mode = mi; m_dtype = di;
      end
    end else if (ab) m_active = 0;
    else if (m_sends == BW + 1) m_active = 0;
    else if (m_loads < BW) begin if (iv) m_loads++; end
    else if (m_settles < SC) m_settles++;
    else if (ordy) m_sends++;
  endtask

  task automatic model_reset();
    m_active = 0; m_loads = 0; m_settles = 0; m_sends = 0;
    m_mode = 4'h0; m_dtype = 0;
  endtask

  task automatic clear_tallies();
    n_load = 0; n_send = 0; n_ov = 0; n_done = 0;
  endtask

  // Called at posedge+1: drive inputs, sample at posedge+3, advance model.
  task automatic step(input bit s, input logic [3:0] mi, input bit di, input bit ab,
                      input bit iv, input bit ordy,
                      output logic [BL-1:0] obs, output logic [BL-1:0] exp);
    start = s; mode_in = mi; dtype_in = di; abort = ab; in_valid = iv; out_ready = ordy;
    #2;
    exp = model_expect(ab, iv, ordy);
    obs = {busy, in_ready, load, send, out_valid, done, mode, dtype, beat_cnt};
    n_load += int'(load); n_send += int'(send); n_ov += int'(out_valid); n_done += int'(done);
    model_update(s, mi, di, ab, iv, ordy);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [BL-1:0] o, e;
    rst = 0;
    #12;
    o = {busy, in_ready, load, send, out_valid, done, mode, dtype, beat_cnt};
    n_cmp++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", o, {BL{1'b0}}); end
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    step(0, 4'h0, 0, 0, 0, 0, o, e);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", o, e); end
  endtask

  task automatic test_basic();
    logic [BL-1:0] o, e;
    int done_cyc = -1;
    clear_tallies();
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      step(c == 0, 4'h2, 1, 0, 1, 1, o, e);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL basic cyc=%0d got=%h exp=%h", c, o, e); end
      if (o[BL-6]) done_cyc = c;
    end
    n_cmp++;
    if (done_cyc != 2 + BW + SC + BW) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", done_cyc, 2 + BW + SC + BW); end
    n_cmp++;
    if (n_load != BW || n_send != BW + 1 || n_ov != BW || n_done != 1) begin
      n_fail++;
      $display("FAIL basic_pulses got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/1", n_load, n_send, n_ov, n_done, BW, BW + 1, BW);
    end
    step(0, 4'h0, 0, 0, 1, 1, o, e);
    n_cmp++;
    if (o !== e || mode !== 4'h2) begin n_fail++; $display("FAIL basic_after got=%h exp=%h", o, e); end
  endtask

  task automatic test_load_stall();
    logic [BL-1:0] o, e;
    int done_cyc = -1;
    bit iv;
    clear_tallies();
    for (int c = 0; c < 400 && done_cyc < 0; c++) begin
      iv = (c >= 1) && ((c - 1) % 3 == 0);
      step(c == 0, 4'h4, 0, 0, iv, 1, o, e);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL load_stall cyc=%0d got=%h exp=%h", c, o, e); end
      if (o[BL-6]) done_cyc = c;
    end
    n_cmp++;
    if (done_cyc != 1 + 3 * (BW - 1) + 1 + SC + BW + 1) begin
      n_fail++; $display("FAIL load_stall_latency got=%0d exp=%0d", done_cyc, 1 + 3 * (BW - 1) + 1 + SC + BW + 1);
    end
    n_cmp++;
    if (n_load != BW) begin n_fail++; $display("FAIL load_stall_pulses got=%0d exp=%0d", n_load, BW); end
  endtask

  task automatic test_send_stall();
    logic [BL-1:0] o, e;
    int done_cyc = -1;
    int s0 = 1 + BW + SC;  // first SEND cycle
    bit stall;
    clear_tallies();
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      stall = (c >= s0 + 10) && (c < s0 + 15);
      step(c == 0, 4'hA, 1, 0, 1, !stall, o, e);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL send_stall cyc=%0d got=%h exp=%h", c, o, e); end
      if (stall) begin
        n_cmp++;
        if (o[BL-4] !== 1'b0 || o[BL-5] !== 1'b0 || o[CW-1:0] !== CW'(10)) begin
          n_fail++; $display("FAIL send_stall_hold cyc=%0d got=%h cnt_exp=10 send/ov_exp=0", c, o);
        end
      end
      if (o[BL-6]) done_cyc = c;
    end
    n_cmp++;
    if (done_cyc != 2 + BW + SC + BW + 5) begin
      n_fail++; $display("FAIL send_stall_latency got=%0d exp=%0d", done_cyc, 2 + BW + SC + BW + 5);
    end
    n_cmp++;
    if (n_send != BW + 1 || n_ov != BW) begin n_fail++; $display("FAIL send_stall_pulses got=%0d/%0d exp=%0d/%0d", n_send, n_ov, BW + 1, BW); end
  endtask

  task automatic test_abort();
    logic [BL-1:0] o, e;
    int done_cyc = -1;
    clear_tallies();
    for (int c = 0; c <= 14; c++) begin
      step(c == 0, 4'h5, 0, c == 13, 1, 1, o, e);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL abort cyc=%0d got=%h exp=%h", c, o, e); end
      if (c == 13) begin
        n_cmp++;
        if (o[BL-3] !== 1'b0 || o[CW-1:0] !== CW'(12)) begin n_fail++; $display("FAIL abort_load got=%h exp load=0 cnt=12", o); end
      end
      if (c == 14) begin
        n_cmp++;
        if (o[BL-1] !== 1'b0) begin n_fail++; $display("FAIL abort_idle busy got=%b exp=0", o[BL-1]); end
      end
    end
    n_cmp++;
    if (n_done != 0) begin n_fail++; $display("FAIL abort_done got=%0d exp=0", n_done); end
    clear_tallies();
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      step(c == 0, 4'h7, 1, 0, 1, 1, o, e);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL abort_rerun cyc=%0d got=%h exp=%h", c, o, e); end
      if (o[BL-6]) done_cyc = c;
    end
    n_cmp++;
    if (n_load != BW || done_cyc != 2 + BW + SC + BW) begin
      n_fail++; $display("FAIL abort_rerun_len got=%0d loads done@%0d exp=%0d loads", n_load, done_cyc, BW);
    end
  endtask

  task automatic test_async_reset();
    logic [BL-1:0] o, e;
    clear_tallies();
    for (int c = 0; c < 1 + BW + SC + 20; c++) begin
      step(c == 0, 4'h9, 1, 0, 1, 1, o, e);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL areset_run cyc=%0d got=%h exp=%h", c, o, e); end
    end
    #1;
    n_cmp++;
    if (beat_cnt !== CW'(20) || send !== 1'b1) begin n_fail++; $display("FAIL areset_pre cnt got=%0d exp=20", beat_cnt); end
    rst = 0;
    #1;
    o = {busy, in_ready, load, send, out_valid, done, mode, dtype, beat_cnt};
    n_cmp++;
    if (o !== '0) begin n_fail++; $display("FAIL areset_immediate got=%h exp=%h", o, {BL{1'b0}}); end
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      step(0, 4'h0, 0, 0, 1, 1, o, e);
      n_cmp++;
      if (o !== e || o[BL-1] !== 1'b0) begin n_fail++; $display("FAIL areset_after cyc=%0d got=%h exp=%h", c, o, e); end
    end
    n_cmp++;
    if (n_done != 0) begin n_fail++; $display("FAIL areset_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_start_busy();
    logic [BL-1:0] o, e;
    bit s;
    clear_tallies();
    for (int c = 0; c < 2 + BW + SC + BW + 6; c++) begin
      s = (c == 0) || (c == 1 + BW);  // second pulse lands in SETTLE
      step(s, (c == 0) ? 4'h3 : 4'hF, c != 0, 0, 1, 1, o, e);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL start_busy cyc=%0d got=%h exp=%h", c, o, e); end
    end
    n_cmp++;
    if (n_done != 1 || mode !== 4'h3 || dtype !== 1'b0) begin
      n_fail++; $display("FAIL start_busy_latch got=done:%0d mode:%h dtype:%b exp=done:1 mode:3 dtype:0", n_done, mode, dtype);
    end
  endtask

  task automatic test_random();
    logic [BL-1:0] o, e;
    int nf0 = n_fail;
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 3) == 0, 4'($urandom), 1'($urandom), $urandom_range(0, 149) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, o, e);
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        if (n_fail - nf0 < 10) $display("FAIL random cyc=%0d got=%h exp=%h", c, o, e);
      end
    end
  endtask

  initial begin
    model_reset();
    clear_tallies();
    test_reset();
    test_basic();
    test_load_stall();
    test_send_stall();
    test_abort();
    test_async_reset();
    test_start_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
